// File: rtl/mem_seq.sv
// Memory request sequencer: turns CPU program/data/char requests into a byte-wide
// address/data beat handshake with an asynchronous external host.
module mem_seq #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] PC_RESET    = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        mreq,
  input  logic [2:0]  mtype,
  output logic        mdone,
  input  logic        ack,
  output logic        rdy,
  output logic [1:0]  bus_ctrl,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic [23:0] pc
);

  typedef enum logic [1:0] {IDLE, BEAT, RELEASE, DONE} state_t;
  typedef enum logic [2:0] {
    PROGN = 3'd0, PROGP = 3'd1, RDATA = 3'd2, WDATA = 3'd3,
    RCHAR = 3'd4, WCHAR = 3'd5, RSVD6 = 3'd6, RSVD7 = 3'd7
  } mtype_t;

  localparam logic [1:0] BEAT_DATA = 2'd3;

  state_t                 state, state_d;
  mtype_t                 typ, req_typ;
  logic [23:0]            taddr;
  logic [7:0]             wdata;
  logic [1:0]             beat;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   is_read, req_rsvd, req_char;

  // Plain flop chain; only the last stage is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync[0] <= ack;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        ack_sync[i] <= ack_sync[i-1];
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign req_typ  = mtype_t'(mtype);
  assign req_rsvd = (req_typ == RSVD6) || (req_typ == RSVD7);
  assign req_char = (req_typ == RCHAR) || (req_typ == WCHAR);
  assign is_read  = (typ == PROGN) || (typ == PROGP) || (typ == RDATA) || (typ == RCHAR);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (mreq)   state_d = req_rsvd ? DONE : BEAT;
      BEAT:    if (ack_s)  state_d = RELEASE;
      RELEASE: if (!ack_s) state_d = (beat == BEAT_DATA) ? DONE : BEAT;
      DONE:    if (!mreq)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      typ      <= PROGN;
      taddr    <= '0;
      wdata    <= '0;
      beat     <= '0;
      data_out <= '0;
      pc       <= PC_RESET;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (mreq) begin
            typ   <= req_typ;
            wdata <= data_in;
            beat  <= req_char ? BEAT_DATA : 2'd0;
            case (req_typ)
              PROGN:   taddr <= pc;
              PROGP:   taddr <= pc - 24'd1;
              default: taddr <= addr;
            endcase
          end
        end
        BEAT: begin
          if (ack_s && beat == BEAT_DATA && is_read)
            data_out <= bus_in;
        end
        RELEASE: begin
          if (!ack_s) begin
            if (beat != BEAT_DATA)
              beat <= beat + 2'd1;
            else if (typ == PROGN)
              pc <= pc + 24'd1;
            else if (typ == PROGP)
              pc <= pc - 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign rdy      = (state == BEAT);
  assign mdone    = (state == DONE);
  assign bus_ctrl = beat;

  always_comb begin
    bus_out = '0;
    case (beat)
      2'd0:    bus_out = taddr[7:0];
      2'd1:    bus_out = taddr[15:8];
      2'd2:    bus_out = taddr[23:16];
      default: bus_out = is_read ? 8'h00 : wdata;
    endcase
  end

endmodule
